// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer controller.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ONE_SHOT = 2'b00,
    PERIODIC = 2'b01,
    TRIANGLE = 2'b10,
    RSVD     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN_DN  = 2'b01,
    RUN_UP  = 2'b10,
    RUN_DN2 = 2'b11
  } state_e;

  localparam int PRESC_W = 8;

endpackage

// File: rtl/universal_binary_counter.sv
// N-bit up/down counter with synchronous clear and parallel load.
// Priority: syn_clr over load over en.
module universal_binary_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (syn_clr)   r_d = '0;
    else if (load) r_d = d;
    else if (en)   r_d = up ? r_q + 1'b1 : r_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

  assign q = r_q;

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: sequences a counter for one-shot, periodic and triangle patterns.
// Optional prescaler enabled with `define TIMER_PRESCALE_EN.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
  input  logic [N-1:0] period,
  input  logic [N-1:0] cmp,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESC_W-1:0] prescale,
`endif
  output logic [N-1:0] count,
  output logic         busy,
  output logic         tick,
  output logic         pwm
);

  state_e       state_q, state_d;
  mode_e        mode_q;
  logic [N-1:0] period_q, cmp_q;
  logic         pwm_q;
  logic         strobe;
  logic         start_ok;
  logic         ctr_clr, ctr_load, ctr_en, ctr_up;
  logic [N-1:0] ctr_d;

  assign start_ok = (state_q == IDLE) && start && !stop;

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d, presc_sh_q;

  always_comb begin
    presc_d = presc_q;
    if (stop)                  presc_d = '0;
    else if (state_q == IDLE)  presc_d = start ? prescale : '0;
    else if (presc_q == '0)    presc_d = presc_sh_q;
    else                       presc_d = presc_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      presc_sh_q <= '0;
    end else begin
      presc_q <= presc_d;
      if (start_ok) presc_sh_q <= prescale;
    end
  end

  assign strobe = (presc_q == '0);
`else
  assign strobe = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    ctr_up   = 1'b0;
    ctr_d    = period_q;
    tick     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ctr_d = period;
          if (mode_e'(mode) == TRIANGLE) begin
            ctr_clr = 1'b1;
            state_d = RUN_UP;
          end else begin
            ctr_load = 1'b1;
            state_d  = RUN_DN;
          end
        end
      end
      RUN_DN: begin
        ctr_en = strobe;
        if (strobe && count == '0) begin
          tick = 1'b1;
          if (mode_q == ONE_SHOT) begin
            ctr_en  = 1'b0;
            state_d = IDLE;
          end else begin
            ctr_load = 1'b1;
          end
        end
      end
      RUN_UP: begin
        ctr_en = strobe;
        ctr_up = 1'b1;
        if (strobe && count == period_q) begin
          // A zero-height triangle parks at 0 and ticks on every step.
          if (period_q == '0) begin
            tick   = 1'b1;
            ctr_en = 1'b0;
          end else begin
            ctr_up  = 1'b0;
            state_d = RUN_DN2;
          end
        end
      end
      RUN_DN2: begin
        ctr_en = strobe;
        if (strobe && count == '0) begin
          tick    = 1'b1;
          ctr_up  = 1'b1;
          state_d = RUN_UP;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a start or a terminal tick.
    if (stop) begin
      ctr_clr  = 1'b1;
      ctr_load = 1'b0;
      ctr_en   = 1'b0;
      tick     = 1'b0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= ONE_SHOT;
      period_q <= '0;
      cmp_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= (state_q != IDLE) && (count < cmp_q);
      if (start_ok) begin
        mode_q   <= mode_e'(mode);
        period_q <= period;
        cmp_q    <= cmp;
      end
    end
  end

  universal_binary_counter #(.N(N)) u_counter (
    .clk     (clk),
    .reset   (!rst_n),
    .syn_clr (ctr_clr),
    .load    (ctr_load),
    .en      (ctr_en),
    .up      (ctr_up),
    .d       (ctr_d),
    .q       (count)
  );

  assign busy = (state_q != IDLE);
  assign pwm  = pwm_q;

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Programmable timer controller that sequences an N-bit up/down/load counter to generate one-shot, periodic and triangle timing patterns. It owns the counter's control word (syn_clr, load, en, up, d), produces a single-cycle `tick` event and a compare-based `pwm` output, and sits between software-visible configuration registers and any block needing timed events.

## Interface
- `N`, 8: counter and period/compare width.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: begin a run. Sampled in IDLE only.
- `stop` input 1: synchronous abort, any state.
- `mode` input 2: run mode. 00 one-shot, 01 periodic, 10 triangle, 11 treated as periodic.
- `period` input N: terminal value.
- `cmp` input N: PWM compare threshold.
- `count` output N: current counter value.
- `busy` output 1: high in any RUN state.
- `tick` output 1: single-cycle event pulse.
- `pwm` output 1: registered compare output.
- `prescale` input 8: present only with `TIMER_PRESCALE_EN`.

## Operation
- States: IDLE, RUN_DN (one-shot/periodic), RUN_UP and RUN_DN2 (triangle).
- On `start` in IDLE, latch `mode`, `period` and `cmp` into shadow registers. Later input changes are ignored until the next start.
  - One-shot/periodic: load `count` = `period`, go to RUN_DN.
  - Triangle: syn_clr, go to RUN_UP.
- RUN_DN: en=1, up=0.
  - When `count`==0: `tick`=1.
  - One-shot: en=0, go to IDLE. `count` holds 0.
  - Periodic: load `period` in the same cycle. This gives a `tick` every `period`+1 cycles.
- RUN_UP: en=1, up=1. When `count`==shadow `period`: count down in the same cycle and go to RUN_DN2.
- RUN_DN2: en=1, up=0. When `count`==0: `tick`=1, count up, go to RUN_UP. The cycle is 2·`period` cycles.
- `period`==0:
  - One-shot: one `tick`.
  - Periodic: `tick` every cycle.
  - Triangle: `count` stays 0, `tick` every cycle.
- `stop`: syn_clr, go to IDLE, `busy`=0, no `tick`.
  - `stop` wins over `start` in the same cycle.
  - `stop` wins over a terminal-count `tick`.
- `start` while busy is ignored.
- `tick` is decoded from registered state and `count` only; there is no input-to-output path except `stop` masking.
- `pwm`: registered `busy` && (`count` < shadow `cmp`). Comparison is unsigned. `cmp`=0 gives constant 0; `cmp` > `period` gives constant 1 while running.

## Timing
- Reset: state IDLE, `count`=0, shadows 0, `busy`=0, `tick`=0, `pwm`=0. Reset mid-run aborts immediately with no `tick`.
- Start sampled at edge k. After edge k: `busy`=1 and `count`=`period` (triangle: 0).
- One-shot: `tick` is high in the cycle after edge k+`period`. `busy` falls after edge k+`period`+1.
- `pwm` lags `count` by one cycle. It falls one cycle after `busy` falls.
- Counter arithmetic is modulo 2^N, but the FSM never lets it wrap: it loads or reverses direction at the terminal values.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - 8-bit prescaler, loaded with `prescale` on `start` and on reaching 0.
  - Counter en, state transitions and `tick` are all qualified by strobe = (prescaler==0).
  - Each count step lasts `prescale`+1 cycles.
  - `stop` and reset clear the prescaler.
- Undefined: no `prescale` port, strobe tied to 1. Behaviour equals the defined case with `prescale`=0.

## Structure
- `timer_ctrl_pkg`: `mode_e` (ONE_SHOT, PERIODIC, TRIANGLE, RSVD), `state_e` (IDLE, RUN_DN, RUN_UP, RUN_DN2), prescaler width constant.
- One sub-module: an instance of `universal_binary_counter` (width N) as the count datapath.
  - Tie its reset to `!rst_n`.
  - `timer_ctrl` contains only the FSM, shadow registers, prescaler, and `tick`/`pwm` logic.

## Test plan
- One-shot, `period`=5, `start` at edge 0 → `count` 5,4,3,2,1,0; `tick` one cycle, when `count`=0; `busy` low after edge 6; `count` holds 0.
- Periodic, `period`=3, `cmp`=2 → `tick` every 4 cycles; `pwm` high for 2 of every 4 cycles, one cycle behind `count`.
- Triangle, `period`=4 → `count` 0,1,2,3,4,3,2,1,0,1…; `tick` at each 0 after a descent; 8-cycle cycle.
- `stop` asserted with `count`=0 in periodic → no `tick`, `count`=0, `busy`=0 next cycle; `start`+`stop` same cycle stays IDLE.
- Change `period`/`cmp`/`mode` and pulse `start` mid-run → ignored. `rst_n` low mid-run → all outputs 0 immediately.
- `TIMER_PRESCALE_EN`, `prescale`=2, one-shot `period`=2 → each `count` value held 3 cycles, one `tick`; `period`=0 edge cases per mode.
